// File: rtl/counter_cmd_ctrl.sv
// Run/stop/clear/direction sequencer for the tick counter: arbitrates front-panel
// buttons against UART command bytes and drives registered counter controls.
module counter_cmd_ctrl #(
    parameter logic [7:0] CMD_RUN   = 8'h52,
    parameter logic [7:0] CMD_CLEAR = 8'h43,
    parameter logic [7:0] CMD_MODE  = 8'h4D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    input  logic       i_sw_mode,
    input  logic       i_tick,
    input  logic       i_cmd_valid,
    input  logic [7:0] i_cmd_data,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic       o_mode,
    output logic [1:0] o_state,
    output logic       o_cmd_ack,
    output logic       o_cmd_err
);
    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    logic [1:0] r_state;
    logic       r_mode_flip;
    logic       r_run_stop;
    logic       r_clear;
    logic       r_mode;
    logic       r_cmd_ack;
    logic       r_cmd_err;

    logic [1:0] w_next;
    logic       w_in_clear;
    logic       w_btn_any;
    logic       w_cmd_known;
    logic       w_cmd_ok;
    logic       w_cmd_bad;
    logic       w_run_req;
    logic       w_clr_req;
    logic       w_target;

    assign w_in_clear  = (r_state == ST_CLEAR);
    assign w_btn_any   = i_btn_run_stop | i_btn_clear;
    assign w_cmd_known = (i_cmd_data == CMD_RUN) | (i_cmd_data == CMD_CLEAR) |
                         (i_cmd_data == CMD_MODE);
    // A command only survives when no button pulse competes and we are not clearing.
    assign w_cmd_ok    = i_cmd_valid & w_cmd_known & ~w_btn_any & ~w_in_clear;
    assign w_cmd_bad   = i_cmd_valid & ~w_cmd_ok;

    assign w_run_req = (i_btn_run_stop & ~w_in_clear) | (w_cmd_ok & (i_cmd_data == CMD_RUN));
    assign w_clr_req = (i_btn_clear    & ~w_in_clear) | (w_cmd_ok & (i_cmd_data == CMD_CLEAR));
    assign w_target  = i_sw_mode ^ r_mode_flip;

    always_comb begin
        w_next = ST_STOP;
        case (r_state)
            ST_STOP: begin
                if (w_clr_req)      w_next = ST_CLEAR;
                else if (w_run_req) w_next = ST_RUN;
                else                w_next = ST_STOP;
            end
            ST_RUN: begin
                if (w_clr_req)      w_next = ST_CLEAR;
                else if (w_run_req) w_next = ST_STOP;
                else                w_next = ST_RUN;
            end
            default: w_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_STOP;
            r_mode_flip <= 1'b0;
            r_run_stop  <= 1'b0;
            r_clear     <= 1'b0;
            r_mode      <= 1'b0;
            r_cmd_ack   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_run_stop  <= (w_next == ST_RUN);
            r_clear     <= (w_next == ST_CLEAR);
            r_cmd_ack   <= w_cmd_ok;
            r_cmd_err   <= w_cmd_bad;
            r_mode_flip <= r_mode_flip ^ (w_cmd_ok & (i_cmd_data == CMD_MODE));
            // While running, direction may only change on a tick boundary.
            if (r_state != ST_RUN || i_tick)
                r_mode <= w_target;
        end
    end

    assign o_state    = r_state;
    assign o_run_stop = r_run_stop;
    assign o_clear    = r_clear;
    assign o_mode     = r_mode;
    assign o_cmd_ack  = r_cmd_ack;
    assign o_cmd_err  = r_cmd_err;
endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Scoreboard bench for counter_cmd_ctrl: a cycle model pushes expected outputs
// as stimulus is driven; they are popped and compared one cycle later.
module tb_counter_cmd_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_run = 1'b0, btn_clr = 1'b0, sw = 1'b0, tick = 1'b0, cv = 1'b0;
    logic [7:0] cd = 8'h00;
    logic       o_run_stop, o_clear, o_mode, o_cmd_ack, o_cmd_err;
    logic [1:0] o_state;

    typedef struct packed {
        logic       run;
        logic       clr;
        logic       mode;
        logic [1:0] st;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // model state
    int   m_state = 0;
    logic m_flip  = 1'b0;
    logic m_mode  = 1'b0;

    always #5 clk = ~clk;

    counter_cmd_ctrl dut (
        .clk(clk), .reset(reset),
        .i_btn_run_stop(btn_run), .i_btn_clear(btn_clr), .i_sw_mode(sw), .i_tick(tick),
        .i_cmd_valid(cv), .i_cmd_data(cd),
        .o_run_stop(o_run_stop), .o_clear(o_clear), .o_mode(o_mode), .o_state(o_state),
        .o_cmd_ack(o_cmd_ack), .o_cmd_err(o_cmd_err)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model of one clock edge given the inputs currently driven.
    task automatic model_push();
        exp_t e;
        logic known, ack, err, rr, cr;
        int   ns;
        known = (cd == 8'h52) || (cd == 8'h43) || (cd == 8'h4D);
        ack = 1'b0; err = 1'b0;
        if (cv) begin
            if (m_state == 2 || btn_run || btn_clr || !known) err = 1'b1;
            else ack = 1'b1;
        end
        rr = (m_state != 2) && (btn_run || (ack && cd == 8'h52));
        cr = (m_state != 2) && (btn_clr || (ack && cd == 8'h43));
        if (m_state != 1 || tick) m_mode = sw ^ m_flip;
        if (ack && cd == 8'h4D) m_flip = ~m_flip;
        if (m_state == 2)  ns = 0;
        else if (cr)       ns = 2;
        else if (rr)       ns = (m_state == 1) ? 0 : 1;
        else               ns = m_state;
        m_state = ns;
        e.run = (ns == 1); e.clr = (ns == 2); e.mode = m_mode;
        e.st = 2'(ns); e.ack = ack; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic br, input logic bc, input logic tk,
                        input logic v, input logic [7:0] d);
        exp_t e;
        btn_run = br; btn_clr = bc; tick = tk; cv = v; cd = d;
        model_push();
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("run_stop", {7'd0, o_run_stop}, {7'd0, e.run});
        chk("clear",    {7'd0, o_clear},    {7'd0, e.clr});
        chk("mode",     {7'd0, o_mode},     {7'd0, e.mode});
        chk("state",    {6'd0, o_state},    {6'd0, e.st});
        chk("cmd_ack",  {7'd0, o_cmd_ack},  {7'd0, e.ack});
        chk("cmd_err",  {7'd0, o_cmd_err},  {7'd0, e.err});
        btn_run = 1'b0; btn_clr = 1'b0; tick = 1'b0; cv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_outs", {o_run_stop, o_clear, o_mode, o_state, o_cmd_ack, o_cmd_err, 1'b0}, 8'h00);
        exp_q.delete();
        m_state = 0; m_flip = 1'b0; m_mode = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk("reset_state", {6'd0, o_state}, 8'h00);
        chk("reset_outs", {3'd0, o_run_stop, o_clear, o_mode, o_cmd_ack, o_cmd_err}, 8'h00);
        reset = 1'b0;

        // 1: run toggle by button
        idle(9); step(1, 0, 0, 0, 0); idle(19); step(1, 0, 0, 0, 0); idle(5);
        // 2: clear from RUN
        step(1, 0, 0, 0, 0); idle(3); step(0, 1, 0, 0, 0); idle(3);
        // 3: both buttons in STOP, then 'R' arriving during CLEAR
        step(1, 1, 0, 0, 0); step(0, 0, 0, 1, 8'h52); idle(2);
        // buttons during CLEAR are ignored
        step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); idle(2);
        // 4: command bytes
        step(0, 0, 0, 1, 8'h52); idle(2); step(0, 0, 0, 1, 8'h58); idle(2);
        step(1, 0, 0, 1, 8'h52); idle(2); step(0, 0, 0, 1, 8'h43); idle(3);
        step(0, 1, 0, 1, 8'h4D); idle(2);
        // 5: direction latched on tick only while running
        step(1, 0, 0, 0, 0); idle(3);
        sw = 1'b1; idle(10); step(0, 0, 1, 0, 0); idle(3);
        step(1, 0, 0, 0, 0); idle(3); step(0, 0, 0, 1, 8'h4D); idle(4);
        // 6: reset while running with mode_flip set, then mode follows switch
        step(1, 0, 0, 0, 0); idle(2);
        do_reset(); idle(3); sw = 1'b0; idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
                0: d = 8'h52;
                1: d = 8'h43;
                2: d = 8'h4D;
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 31) == 0) sw = ~sw;
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
